// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes and receiver states.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RESET_VAL so an idle line stays idle.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, optional odd/even parity,
// framing check and a one-cycle valid strobe per word.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT  = 434,
    parameter int DATA_BITS       = 8,
    parameter int CLOCK_CTR_WIDTH = 32,
    parameter int D_IDX_WIDTH     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic [1:0]           parity_type,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 busy
);

    localparam logic [CLOCK_CTR_WIDTH-1:0] LAST =
        CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT - 1);
    localparam logic [CLOCK_CTR_WIDTH-1:0] HALF =
        CLOCK_CTR_WIDTH'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [D_IDX_WIDTH-1:0] IDX_LAST =
        D_IDX_WIDTH'(DATA_BITS - 1);

    rx_state_t state, state_n;

    logic                       rx_s;
    logic [CLOCK_CTR_WIDTH-1:0] ctr;
    logic [D_IDX_WIDTH-1:0]     idx;
    logic [DATA_BITS-1:0]       shift;
    logic [1:0]                 parity_reg;
    logic                       p_err;
    logic                       bit_end;
    logic                       half_hit;
    logic                       last_bit;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (rx_s)
    );

    assign bit_end  = (ctr == LAST);
    assign half_hit = (ctr == HALF);
    assign last_bit = (idx == IDX_LAST);
    assign busy     = (state != RX_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            RX_IDLE:
                if (!rx_s) state_n = RX_START;
            RX_START:
                if (half_hit) state_n = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:
                if (bit_end && last_bit)
                    state_n = (parity_reg != PARITY_NONE) ?
                              RX_PARITY : RX_STOP;
            RX_PARITY:
                if (bit_end) state_n = RX_STOP;
            RX_STOP:
                if (bit_end) state_n = rx_s ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH:
                if (rx_s) state_n = RX_IDLE;
            default:
                state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr           <= '0;
            idx           <= '0;
            shift         <= '0;
            parity_reg    <= PARITY_NONE;
            p_err         <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    ctr        <= '0;
                    idx        <= '0;
                    p_err      <= 1'b0;
                    parity_reg <= (parity_type == 2'd3) ?
                                  PARITY_NONE : parity_type;
                end
                RX_START:
                    ctr <= half_hit ? '0 : ctr + 1'b1;
                RX_DATA:
                    if (bit_end) begin
                        ctr        <= '0;
                        shift[idx] <= rx_s;
                        idx        <= last_bit ? '0 : idx + 1'b1;
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                RX_PARITY:
                    if (bit_end) begin
                        ctr   <= '0;
                        // odd wants total ones = 1, even wants 0
                        p_err <= (^shift ^ rx_s) ^
                                 (parity_reg == PARITY_ODD);
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                RX_STOP:
                    if (bit_end) begin
                        ctr           <= '0;
                        data_out      <= shift;
                        parity_error  <= p_err &
                                         (parity_reg != PARITY_NONE);
                        framing_error <= ~rx_s;
                        data_valid    <= 1'b1;
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                RX_WAIT_HIGH:
                    ctr <= '0;
                default:
                    ctr <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx with a frame-level
// transmitter model driving the serial line.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int H   = (CPB - 1) / 2;
    localparam int DB  = 8;
    localparam int PER = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          serial_in = 1'b1;
    logic [1:0]    parity_type = 2'd0;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          parity_error;
    logic          framing_error;
    logic          busy;

    typedef struct {
        logic [DB-1:0] data;
        logic          perr;
        logic          ferr;
        longint        t_exp;
    } exp_t;

    exp_t   sb[$];
    exp_t   e;
    int     total = 0;
    int     bad = 0;
    int     valid_cnt = 0;
    longint last_valid = 0;
    longint prev_valid = 0;

    uart_rx #(
        .CLOCKS_PER_BIT (CPB),
        .DATA_BITS      (DB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .parity_type   (parity_type),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #(PER / 2) clk = ~clk;

    initial begin
        #(500_000);
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, longint got, longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && data_valid) begin
            prev_valid = last_valid;
            last_valid = $time;
            valid_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid got=%0h want=none",
                         data_out);
            end else begin
                e = sb.pop_front();
                check("data", longint'(data_out), longint'(e.data));
                check("perr", longint'(parity_error), longint'(e.perr));
                check("ferr", longint'(framing_error), longint'(e.ferr));
                check("latency", longint'($time), e.t_exp);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_bit(logic b);
        serial_in = b;
        tick(CPB);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_data"}, longint'(data_out), 0);
        check({tag, "_valid"}, longint'(data_valid), 0);
        check({tag, "_perr"}, longint'(parity_error), 0);
        check({tag, "_ferr"}, longint'(framing_error), 0);
        check({tag, "_busy"}, longint'(busy), 0);
    endtask

    // Frame model: parity enabled only for codes 1/2, latched at start.
    task automatic send(logic [DB-1:0] d, logic [1:0] pt,
                        logic flip, logic stop, logic [1:0] pt_after);
        logic   en;
        logic   pbit;
        longint t_edge;
        exp_t   x;
        en   = (pt == 2'd1) || (pt == 2'd2);
        pbit = (pt == 2'd1) ? ($countones(d) % 2 == 0)
                            : ($countones(d) % 2 == 1);
        pbit = pbit ^ flip;
        parity_type = pt;
        t_edge = longint'($time) - 1;
        x.data  = d;
        x.perr  = en && flip;
        x.ferr  = !stop;
        x.t_exp = t_edge + PER / 2 +
                  longint'(4 + H + (DB + int'(en) + 1) * CPB) * PER;
        sb.push_back(x);
        tx_bit(1'b0);
        parity_type = pt_after;
        for (int i = 0; i < DB; i++) tx_bit(d[i]);
        if (en) tx_bit(pbit);
        tx_bit(stop);
    endtask

    initial begin
        int vc;
        logic [DB-1:0] rd;
        logic stop_r;
        #3;
        check_reset_outputs("reset");
        tick(3);
        rst = 1'b0;
        tick(5);

        vc = valid_cnt;
        send(8'hA5, 2'd0, 1'b0, 1'b1, 2'd0);
        tick(2);
        check("a5_pulses", valid_cnt - vc, 1);
        check("a5_busy", longint'(busy), 0);

        send(8'h01, 2'd1, 1'b0, 1'b1, 2'd1);
        send(8'h01, 2'd1, 1'b1, 1'b1, 2'd1);
        send(8'h03, 2'd2, 1'b0, 1'b1, 2'd2);
        tick(4);

        vc = valid_cnt;
        parity_type = 2'd0;
        serial_in = 1'b0;
        tick(4);
        serial_in = 1'b1;
        check("glitch_busy_hi", longint'(busy), 1);
        tick(8);
        check("glitch_busy_lo", longint'(busy), 0);
        tick(30);
        check("glitch_pulses", valid_cnt - vc, 0);

        vc = valid_cnt;
        send(8'h5A, 2'd0, 1'b0, 1'b0, 2'd0);
        tick(40);
        check("brk_pulses", valid_cnt - vc, 1);
        check("brk_busy_wait", longint'(busy), 1);
        serial_in = 1'b1;
        tick(20);
        check("brk_busy_lo", longint'(busy), 0);
        send(8'h11, 2'd0, 1'b0, 1'b1, 2'd0);
        tick(4);

        parity_type = 2'd0;
        rd = 8'hC3;
        tx_bit(1'b0);
        for (int i = 0; i < 3; i++) tx_bit(rd[i]);
        serial_in = rd[3];
        tick(CPB / 2);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        serial_in = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(5);
        send(8'h3C, 2'd0, 1'b0, 1'b1, 2'd0);
        tick(4);

        send(8'h96, 2'd3, 1'b0, 1'b1, 2'd2);
        tick(4);

        send(8'hFF, 2'd0, 1'b0, 1'b1, 2'd0);
        send(8'h00, 2'd0, 1'b0, 1'b1, 2'd0);
        tick(4);
        check("b2b_gap", last_valid - prev_valid, 160 * PER);

        for (int n = 0; n < 24; n++) begin
            rd     = DB'($urandom);
            stop_r = ($urandom_range(0, 5) != 0);
            send(rd, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), stop_r,
                 2'($urandom_range(0, 3)));
            serial_in = 1'b1;
            tick(4 + CPB * $urandom_range(0, 2));
        end

        for (int i = 0; i < 500 && sb.size() > 0; i++) tick(1);
        check("sb_drain", longint'(sb.size()), 0);
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
